prbs_symbol_gen: RTL and testbench
==================================

PRBS_SYMBOL_GEN -- requirements
Module: prbs_symbol_gen

Interface
REQ-001 SHALL have parameter LFSR_W, default 13: LFSR register width, legal 3..32.
REQ-002 SHALL have parameter TAPS, default 13'h100D: feedback tap mask, bit i set means state[i] is XORed into feedback.
REQ-003 SHALL have parameter SEED, default 13'h000F: reset and substitute seed; nonzero.
REQ-004 SHALL have parameter SYM_BITS, default 4: bits per QAM symbol, legal 1..8.
REQ-005 SHALL have port clock  input  1  all state updates on rising edge.
REQ-006 SHALL have port reset  input  1  asynchronous, active-high.
REQ-007 SHALL have port load_seed  input  1  synchronous seed-load strobe.
REQ-008 SHALL have port seed  input  LFSR_W  value loaded on load_seed.
REQ-009 SHALL have port sym_ready  input  1  downstream accepts sym_data.
REQ-010 SHALL have port sym_valid  output  1  sym_data holds a complete symbol.
REQ-011 SHALL have port sym_data  output  SYM_BITS  assembled symbol.
REQ-012 SHALL have port sym_count  output  16  count of accepted symbols.
REQ-013 SHALL have port seed_err  output  1  sticky flag: a zero seed was substituted.

Function
REQ-014 SHALL compute fb as the XOR of state[i] over all i with TAPS[i]=1.
REQ-015 SHALL update state to {state[LFSR_W-2:0], fb} on each shift.
REQ-016 SHALL shift fb into the symbol register LSB each shift, so the first generated bit ends in sym_data MSB.
REQ-017 SHALL implement FSM state FILL: one shift per cycle, bit counter increments; after the SYM_BITS-th shift, go to HOLD with sym_valid=1.
REQ-018 SHALL implement FSM state HOLD: no shifting; sym_data and state stable; on sym_valid&&sym_ready, go to FILL, clear bit counter, drop sym_valid.
REQ-019 SHALL assert sym_valid at the earliest SYM_BITS cycles after reset release; throughput is one symbol per SYM_BITS+1 cycles with sym_ready held high.
REQ-020 SHALL increment sym_count on each accepted handshake, wrapping 16'hFFFF to 0.
REQ-021 SHALL give load_seed priority over FSM activity: state<=seed, bit counter cleared, FSM to FILL, sym_valid dropped; any partial or held symbol discarded and not counted.
REQ-022 SHALL load SEED instead when load_seed occurs with seed==0, and set seed_err; seed_err clears only on reset.
REQ-023 SHALL give load_seed priority when it coincides with an accepting handshake: the handshake is ignored and sym_count is not incremented.
REQ-024 SHALL ignore sym_ready while in FILL.

Reset
REQ-025 SHALL on reset set: state=SEED, FSM=FILL, bit counter=0, sym_data=0, sym_valid=0, sym_count=0, seed_err=0.
REQ-026 SHALL abort a symbol in progress on reset mid-operation; no partial symbol is emitted after release.

Configuration
REQ-027 SHALL, when macro PRBS_ERR_INJECT_EN is defined, add input err_inject (1 bit); a one-cycle pulse sets a pending flag, and the next symbol completing in FILL has its LSB inverted, after which the flag clears.
REQ-028 SHALL set the pending flag if err_inject coincides with symbol completion, affecting the following symbol; reset and load_seed clear the flag.
REQ-029 SHALL, without PRBS_ERR_INJECT_EN, have no err_inject port and never invert symbol bits.

Verification
REQ-030 SHALL cover: default params, reset release, sym_ready=1 -> symbols 4'hF, 4'hF, 4'hA; state after third is 13'h1FFA; sym_count=3.
REQ-031 SHALL cover: sym_ready=0 for 10 cycles after first sym_valid -> sym_data stays 4'hF, sym_valid high, sym_count 0; then ready -> count 1.
REQ-032 SHALL cover: load_seed with seed=0 during FILL -> state 13'h000F, seed_err=1, first symbol after load 4'hF.
REQ-033 SHALL cover: load_seed coincident with handshake -> sym_count unchanged, sym_valid low next cycle.
REQ-034 SHALL cover: reset asserted mid-FILL after 2 shifts -> all outputs reset values immediately; sequence restarts at 4'hF.
REQ-035 SHALL cover, with PRBS_ERR_INJECT_EN: err_inject pulse before first completion -> first symbol 4'hE, second 4'hF.

Source files
------------

// File: rtl/prbs_symbol_gen.sv
// prbs_symbol_gen: Fibonacci LFSR PRBS packed MSB-first into QAM symbols.
// Define PRBS_ERR_INJECT_EN to add err_inject (flips one symbol LSB).
module prbs_symbol_gen #(
  parameter int unsigned       LFSR_W   = 13,
  parameter logic [LFSR_W-1:0] TAPS     = 13'h100D,
  parameter logic [LFSR_W-1:0] SEED     = 13'h000F,
  parameter int unsigned       SYM_BITS = 4
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                load_seed,
  input  logic [LFSR_W-1:0]   seed,
  input  logic                sym_ready,
  output logic                sym_valid,
  output logic [SYM_BITS-1:0] sym_data,
  output logic [15:0]         sym_count,
  output logic                seed_err
`ifdef PRBS_ERR_INJECT_EN
  ,
  input  logic                err_inject
`endif
);

  localparam int CW = $clog2(SYM_BITS + 1);

  typedef enum logic {
    FILL,
    HOLD
  } fsm_t;

  fsm_t                fsm_q, fsm_d;
  logic [LFSR_W-1:0]   lfsr_q, lfsr_d;
  logic [SYM_BITS-1:0] sym_q, sym_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [15:0]         count_q, count_d;
  logic                err_q, err_d;
  logic                fb;
  logic                last;
  logic                flip;

  assign fb   = ^(lfsr_q & TAPS);
  assign last = (cnt_q == CW'(SYM_BITS - 1));

`ifdef PRBS_ERR_INJECT_EN
  logic pend_q, pend_d;

  assign flip = pend_q & last;

  // Pending flip: armed by a pulse, consumed by the next completing symbol.
  always_comb begin
    pend_d = pend_q;
    if (load_seed)
      pend_d = 1'b0;
    else if (err_inject)
      pend_d = 1'b1;
    else if (fsm_q == FILL && last)
      pend_d = 1'b0;
  end

  // Pending flag register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      pend_q <= 1'b0;
    else
      pend_q <= pend_d;
  end
`else
  assign flip = 1'b0;
`endif

  // Next state: seed load wins, then FILL shifting or HOLD handshake.
  always_comb begin
    fsm_d   = fsm_q;
    lfsr_d  = lfsr_q;
    sym_d   = sym_q;
    cnt_d   = cnt_q;
    count_d = count_q;
    err_d   = err_q;
    if (load_seed) begin
      fsm_d = FILL;
      cnt_d = '0;
      if (seed == '0) begin
        lfsr_d = SEED;
        err_d  = 1'b1;
      end else begin
        lfsr_d = seed;
      end
    end else begin
      unique case (fsm_q)
        FILL: begin
          lfsr_d = {lfsr_q[LFSR_W-2:0], fb};
          sym_d  = SYM_BITS'({sym_q, fb ^ flip});
          if (last) begin
            fsm_d = HOLD;
            cnt_d = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        HOLD: begin
          if (sym_ready) begin
            fsm_d   = FILL;
            cnt_d   = '0;
            count_d = count_q + 16'd1;
          end
        end
        default: fsm_d = FILL;
      endcase
    end
  end

  // State registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      fsm_q   <= FILL;
      lfsr_q  <= SEED;
      sym_q   <= '0;
      cnt_q   <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      fsm_q   <= fsm_d;
      lfsr_q  <= lfsr_d;
      sym_q   <= sym_d;
      cnt_q   <= cnt_d;
      count_q <= count_d;
      err_q   <= err_d;
    end
  end

  assign sym_valid = (fsm_q == HOLD);
  assign sym_data  = sym_q;
  assign sym_count = count_q;
  assign seed_err  = err_q;

endmodule

// File: tb/tb_prbs_symbol_gen.sv
// tb_prbs_symbol_gen: vector table, corner sequences, random vs model.
// Define PRBS_ERR_INJECT_EN to also exercise err_inject.
module tb_prbs_symbol_gen;

  localparam int          W     = 13;
  localparam int          SB    = 4;
  localparam logic [12:0] TAPS  = 13'h100D;
  localparam logic [12:0] SEED  = 13'h000F;
  localparam int          MASK  = 32'h1FFF;
  localparam int          SMASK = 32'hF;

  logic          clock = 1'b0;
  logic          reset;
  logic          load_seed;
  logic [W-1:0]  seed;
  logic          sym_ready;
  logic          sym_valid;
  logic [SB-1:0] sym_data;
  logic [15:0]   sym_count;
  logic          seed_err;
`ifdef PRBS_ERR_INJECT_EN
  logic          err_inject;
`endif

  int checks   = 0;
  int failures = 0;

  prbs_symbol_gen dut (
    .clock     (clock),
    .reset     (reset),
    .load_seed (load_seed),
    .seed      (seed),
    .sym_ready (sym_ready),
    .sym_valid (sym_valid),
    .sym_data  (sym_data),
    .sym_count (sym_count),
    .seed_err  (seed_err)
`ifdef PRBS_ERR_INJECT_EN
    ,
    .err_inject(err_inject)
`endif
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        rdy;
    int          cyc;
    logic        ev;
    logic [3:0]  ed;
    logic [15:0] ec;
  } vec_t;

  vec_t tbl[10];

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
  endtask

  // Reference: bit stream from the LFSR, packed into symbols.
  int m_s, m_acc, m_have, m_cnt;
  bit m_valid, m_err;

  function automatic int nbit(input int s);
    return $countones(s & int'(TAPS)) & 1;
  endfunction

  task automatic model_step(input bit rdy, input bit ld, input int sd);
    int b;
    if (ld) begin
      m_s     = (sd != 0) ? sd : int'(SEED);
      if (sd == 0) m_err = 1'b1;
      m_have  = 0;
      m_valid = 1'b0;
    end else if (m_valid) begin
      if (rdy) begin
        m_cnt   = (m_cnt + 1) & 32'hFFFF;
        m_valid = 1'b0;
        m_have  = 0;
      end
    end else begin
      b      = nbit(m_s);
      m_s    = ((m_s << 1) | b) & MASK;
      m_acc  = ((m_acc << 1) | b) & SMASK;
      m_have = m_have + 1;
      if (m_have == SB) m_valid = 1'b1;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{1'b1, 3,  1'b0, 4'h0, 16'd0};
    tbl[1] = '{1'b1, 1,  1'b1, 4'hF, 16'd0};
    tbl[2] = '{1'b1, 1,  1'b0, 4'h0, 16'd1};
    tbl[3] = '{1'b1, 4,  1'b1, 4'hF, 16'd1};
    tbl[4] = '{1'b1, 1,  1'b0, 4'h0, 16'd2};
    tbl[5] = '{1'b1, 4,  1'b1, 4'hA, 16'd2};
    tbl[6] = '{1'b1, 1,  1'b0, 4'h0, 16'd3};
    tbl[7] = '{1'b0, 4,  1'b1, 4'h1, 16'd3};
    tbl[8] = '{1'b0, 10, 1'b1, 4'h1, 16'd3};
    tbl[9] = '{1'b1, 1,  1'b0, 4'h0, 16'd4};

    reset     = 1'b1;
    load_seed = 1'b0;
    seed      = '0;
    sym_ready = 1'b0;
`ifdef PRBS_ERR_INJECT_EN
    err_inject = 1'b0;
`endif
    tick(2);
    chk("rst_valid", sym_valid, 0);
    chk("rst_data", sym_data, 0);
    chk("rst_count", sym_count, 0);
    chk("rst_err", seed_err, 0);
    chk("rst_lfsr", dut.lfsr_q, SEED);

    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      sym_ready = tbl[i].rdy;
      tick(tbl[i].cyc);
      chk($sformatf("tbl%0d_valid", i), sym_valid, tbl[i].ev);
      if (tbl[i].ev) chk($sformatf("tbl%0d_data", i), sym_data, tbl[i].ed);
      chk($sformatf("tbl%0d_count", i), sym_count, tbl[i].ec);
      if (i == 5) chk("third_lfsr", dut.lfsr_q, 13'h1FFA);
    end

    // Backpressure on the first symbol.
    do_reset();
    sym_ready = 1'b0;
    tick(4);
    chk("bp_valid0", sym_valid, 1);
    chk("bp_data0", sym_data, 4'hF);
    tick(10);
    chk("bp_valid", sym_valid, 1);
    chk("bp_data", sym_data, 4'hF);
    chk("bp_count", sym_count, 0);
    sym_ready = 1'b1;
    tick(1);
    chk("bp_count1", sym_count, 1);
    chk("bp_drop", sym_valid, 0);

    // Zero seed load mid-FILL.
    do_reset();
    sym_ready = 1'b1;
    tick(2);
    load_seed = 1'b1;
    seed      = '0;
    tick(1);
    load_seed = 1'b0;
    chk("zs_lfsr", dut.lfsr_q, 13'h000F);
    chk("zs_err", seed_err, 1);
    chk("zs_valid", sym_valid, 0);
    tick(3);
    chk("zs_early", sym_valid, 0);
    tick(1);
    chk("zs_valid4", sym_valid, 1);
    chk("zs_data", sym_data, 4'hF);

    // Seed load coincident with an accepting handshake.
    tick(1);
    chk("co_count1", sym_count, 1);
    tick(4);
    chk("co_hold", sym_valid, 1);
    load_seed = 1'b1;
    seed      = 13'h0ABC;
    tick(1);
    load_seed = 1'b0;
    chk("co_count", sym_count, 1);
    chk("co_valid", sym_valid, 0);
    chk("co_lfsr", dut.lfsr_q, 13'h0ABC);
    chk("co_err", seed_err, 1);

    // Asynchronous reset mid-FILL.
    do_reset();
    sym_ready = 1'b1;
    load_seed = 1'b1;
    seed      = '0;
    tick(1);
    load_seed = 1'b0;
    tick(5);
    chk("ar_pre_count", sym_count, 1);
    tick(2);
    #2 reset = 1'b1;
    #1;
    chk("ar_valid", sym_valid, 0);
    chk("ar_data", sym_data, 0);
    chk("ar_count", sym_count, 0);
    chk("ar_err", seed_err, 0);
    chk("ar_lfsr", dut.lfsr_q, SEED);
    @(posedge clock);
    #1 reset = 1'b0;
    tick(3);
    chk("ar_early", sym_valid, 0);
    tick(1);
    chk("ar_valid4", sym_valid, 1);
    chk("ar_data4", sym_data, 4'hF);

`ifdef PRBS_ERR_INJECT_EN
    do_reset();
    sym_ready  = 1'b1;
    err_inject = 1'b1;
    tick(1);
    err_inject = 1'b0;
    tick(3);
    chk("ei_valid", sym_valid, 1);
    chk("ei_data1", sym_data, 4'hE);
    tick(5);
    chk("ei_valid2", sym_valid, 1);
    chk("ei_data2", sym_data, 4'hF);
`endif

    // Randomized traffic against the reference.
    do_reset();
    m_s     = int'(SEED);
    m_acc   = 0;
    m_have  = 0;
    m_cnt   = 0;
    m_valid = 1'b0;
    m_err   = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      bit r, l;
      int s;
      r = ($urandom_range(0, 9) < 7);
      l = ($urandom_range(0, 29) == 0);
      s = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom & MASK);
      sym_ready = r;
      load_seed = l;
      seed      = W'(s);
      tick(1);
      model_step(r, l, s);
      chk($sformatf("rnd%0d_valid", c), sym_valid, m_valid);
      if (m_valid) chk($sformatf("rnd%0d_data", c), sym_data, m_acc);
      chk($sformatf("rnd%0d_count", c), sym_count, m_cnt);
      chk($sformatf("rnd%0d_err", c), seed_err, m_err);
    end
    load_seed = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
